// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the byte-stream instruction loader.
// Holds the FSM state encoding and the stream framing sizes.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_ERR
  } loader_state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int ADDR_SHIFT = 2;

  // Word index to word-aligned byte address, zero-extended.
  function automatic logic [31:0] word_addr(input logic [15:0] idx);
    return 32'(idx) << ADDR_SHIFT;
  endfunction

endpackage

// File: rtl/instr_loader_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream; pulses
// word_valid_o for one cycle after the 4th byte of a word is taken.
module word_packer
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic        valid_q, valid_d;

  always_comb begin
    word_d  = word_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    if (clr_i) begin
      idx_d = '0;
    end else if (byte_valid_i) begin
      // First byte received ends up in the least-significant lane.
      word_d  = {byte_i, word_q[31:8]};
      idx_d   = idx_q + 2'd1;
      valid_d = (idx_q == 2'(WORD_BYTES - 1));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;

endmodule

// File: rtl/instr_loader.sv
// Instruction memory write-side loader: parses a length-prefixed byte
// stream, writes words to memory and holds the core in reset meanwhile.
module instr_loader
  import loader_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_req_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        core_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  loader_state_t state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   word_idx_q, word_idx_d;
  logic [7:0]    len_lo_q, len_lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          core_rst_q, core_rst_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          pk_valid, pk_clr, word_valid;
  logic [31:0]   word;
  logic [16:0]   n_hdr;
  logic          tmo;

  assign n_hdr    = {1'b0, rx_data_i, len_lo_q};
  assign tmo      = (cnt_q == CW'(TIMEOUT_CYC - 1));
  assign pk_valid = rx_valid_i && !load_req_i && (state_q == S_DATA);
  assign pk_clr   = load_req_i || (state_q != S_DATA);

  word_packer u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (pk_clr),
    .byte_valid_i (pk_valid),
    .byte_i       (rx_data_i),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    len_lo_d   = len_lo_q;
    word_idx_d = word_idx_q;
    cnt_d      = '0;
    done_d     = 1'b0;
    if (load_req_i) begin
      state_d    = S_LEN_LO;
      word_idx_d = '0;
    end else begin
      unique case (state_q)
        S_LEN_LO: begin
          if (rx_valid_i) begin
            len_lo_d = rx_data_i;
            state_d  = S_LEN_HI;
          end else if (tmo) state_d = S_ERR;
          else cnt_d = cnt_q + 1'b1;
        end
        S_LEN_HI: begin
          if (rx_valid_i) begin
            if (n_hdr == 17'd0 || n_hdr > 17'(MEM_WORDS)) begin
              state_d = S_ERR;
            end else begin
              state_d    = S_DATA;
              len_d      = n_hdr[15:0];
              word_idx_d = '0;
            end
          end else if (tmo) state_d = S_ERR;
          else cnt_d = cnt_q + 1'b1;
        end
        S_DATA: begin
          if (rx_valid_i) cnt_d = '0;
          else if (tmo) state_d = S_ERR;
          else cnt_d = cnt_q + 1'b1;
          // The write cycle of the final word ends the load at this edge.
          if (word_valid) begin
            word_idx_d = word_idx_q + 16'd1;
            if (word_idx_q == len_q - 16'd1) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    busy_d     = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA);
    core_rst_d = (state_d != S_IDLE);
    err_d      = (state_d == S_ERR);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      len_lo_q   <= '0;
      word_idx_q <= '0;
      cnt_q      <= '0;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      len_lo_q   <= len_lo_d;
      word_idx_q <= word_idx_d;
      cnt_q      <= cnt_d;
      core_rst_q <= core_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign mem_we_o    = word_valid;
  assign mem_wdata_o = word;
  assign mem_addr_o  = word_addr(word_idx_q);
  assign core_rst_o  = core_rst_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: vector table, directed corner
// sequences and randomized loads checked against a stream-level model.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst, load_req, rx_valid;
  logic [7:0]  rx_data;
  logic        mem_we, core_rst, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;

  int n_pass = 0;
  int n_chk  = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [7:0]  stream_q[$];
  int          done_cnt;
  time         last_we_t, done_t;

  instr_loader #(.MEM_WORDS(1024), .TIMEOUT_CYC(100)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_req_i  (load_req),
    .rx_valid_i  (rx_valid),
    .rx_data_i   (rx_data),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .core_rst_o  (core_rst),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  // Capture memory writes and completion pulses away from the active edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
      last_we_t = $time;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_t = $time;
    end
  end

  typedef struct {
    int             nb;
    logic [0:9][7:0] b;
    logic           exp_err;
    int             exp_nw;
    logic [31:0]    d0;
    logic [31:0]    d1;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic pulse_req();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
  endtask

  task automatic wait_end(input string nm);
    for (int c = 0; c < 300; c++) begin
      if (err === 1'b1 || done_cnt > 0) break;
      @(negedge clk);
    end
    chk($sformatf("%s finished", nm), 32'(err === 1'b1 || done_cnt > 0), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // Reference: derive the expected writes/outcome from the byte stream alone.
  task automatic run_load(input string nm);
    int hn, plen, nw;
    logic bad, ok;
    clear_mon();
    pulse_req();
    foreach (stream_q[i]) begin
      send_byte(stream_q[i]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_end(nm);
    hn   = (stream_q.size() >= 2) ? int'({stream_q[1], stream_q[0]}) : -1;
    bad  = (hn <= 0) || (hn > 1024);
    plen = stream_q.size() - 2;
    nw   = bad ? 0 : ((plen / 4 < hn) ? plen / 4 : hn);
    ok   = !bad && (plen >= 4 * hn);
    $display("load %s: N=%0d bytes=%0d writes=%0d err=%0b done=%0d", nm, hn,
             stream_q.size(), wa_q.size(), err, done_cnt);
    chk($sformatf("%s nwrites", nm), 32'(wa_q.size()), 32'(nw));
    for (int i = 0; i < nw && i < wa_q.size(); i++) begin
      chk($sformatf("%s addr%0d", nm, i), wa_q[i], 32'(4 * i));
      chk($sformatf("%s data%0d", nm, i), wd_q[i],
          {stream_q[2+4*i+3], stream_q[2+4*i+2], stream_q[2+4*i+1], stream_q[2+4*i]});
    end
    chk($sformatf("%s err", nm), 32'(err), 32'(!ok));
    chk($sformatf("%s done", nm), 32'(done_cnt), 32'(ok));
    chk($sformatf("%s core_rst", nm), 32'(core_rst), 32'(!ok));
    if (ok) chk($sformatf("%s done_delay", nm), 32'(done_t - last_we_t), 32'd10);
  endtask

  initial begin
    rst = 1'b0; load_req = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    done_cnt = 0; last_we_t = 0; done_t = 0;

    vecs[0] = '{10, 80'h0200_7856_3412_EFBE_ADDE, 1'b0, 2, 32'h12345678, 32'hDEADBEEF};
    vecs[1] = '{2,  80'h0000_0000_0000_0000_0000, 1'b1, 0, 32'h0, 32'h0};
    vecs[2] = '{2,  80'h0104_0000_0000_0000_0000, 1'b1, 0, 32'h0, 32'h0};
    vecs[3] = '{6,  80'h0100_1122_3344_0000_0000, 1'b0, 1, 32'h44332211, 32'h0};
    vecs[4] = '{5,  80'h0100_AABB_CC00_0000_0000, 1'b1, 0, 32'h0, 32'h0};

    // Asynchronous reset asserted mid-cycle.
    #12 rst = 1'b1;
    #1;
    chk("rst core_rst", 32'(core_rst), 32'd1);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel core_rst held", 32'(core_rst), 32'd1);
    @(negedge clk);
    chk("rel core_rst low", 32'(core_rst), 32'd0);
    $display("reset: core_rst=%0b busy=%0b", core_rst, busy);

    // Vector table, bytes back-to-back.
    for (int v = 0; v < 5; v++) begin
      clear_mon();
      pulse_req();
      chk($sformatf("v%0d busy", v), 32'(busy), 32'd1);
      chk($sformatf("v%0d core_rst in load", v), 32'(core_rst), 32'd1);
      for (int i = 0; i < vecs[v].nb; i++) send_byte(vecs[v].b[i]);
      wait_end($sformatf("v%0d", v));
      $display("vec %0d: writes=%0d err=%0b done=%0d", v, wa_q.size(), err, done_cnt);
      chk($sformatf("v%0d nwrites", v), 32'(wa_q.size()), 32'(vecs[v].exp_nw));
      if (vecs[v].exp_nw > 0 && wa_q.size() > 0) begin
        chk($sformatf("v%0d addr0", v), wa_q[0], 32'h0);
        chk($sformatf("v%0d data0", v), wd_q[0], vecs[v].d0);
      end
      if (vecs[v].exp_nw > 1 && wa_q.size() > 1) begin
        chk($sformatf("v%0d addr1", v), wa_q[1], 32'h4);
        chk($sformatf("v%0d data1", v), wd_q[1], vecs[v].d1);
      end
      chk($sformatf("v%0d err", v), 32'(err), 32'(vecs[v].exp_err));
      chk($sformatf("v%0d done", v), 32'(done_cnt), 32'(!vecs[v].exp_err));
      chk($sformatf("v%0d core_rst", v), 32'(core_rst), 32'(vecs[v].exp_err));
      if (!vecs[v].exp_err) chk($sformatf("v%0d done_delay", v), 32'(done_t - last_we_t), 32'd10);
    end

    // Write latency and completion timing, cycle by cycle.
    clear_mon();
    pulse_req();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    chk("lat we", 32'(mem_we), 32'd1);
    chk("lat addr", mem_addr, 32'h0);
    chk("lat data", mem_wdata, 32'h44332211);
    chk("lat core_rst", 32'(core_rst), 32'd1);
    @(negedge clk);
    chk("cmp we low", 32'(mem_we), 32'd0);
    chk("cmp done", 32'(done), 32'd1);
    chk("cmp core_rst", 32'(core_rst), 32'd0);
    @(negedge clk);
    chk("cmp done pulse", 32'(done), 32'd0);
    $display("latency: writes=%0d", wa_q.size());

    // Timeout exactly TIMEOUT_CYC cycles after the last byte.
    clear_mon();
    pulse_req();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    repeat (99) @(negedge clk);
    chk("tmo early", 32'(err), 32'd0);
    @(negedge clk);
    chk("tmo err", 32'(err), 32'd1);
    chk("tmo core_rst", 32'(core_rst), 32'd1);
    chk("tmo busy", 32'(busy), 32'd0);
    chk("tmo nwrites", 32'(wa_q.size()), 32'd0);
    $display("timeout: err=%0b writes=%0d", err, wa_q.size());

    // Restart mid-load; the byte coinciding with load_req is discarded.
    clear_mon();
    pulse_req();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    load_req = 1'b1; rx_valid = 1'b1; rx_data = 8'h05;
    @(negedge clk);
    load_req = 1'b0; rx_valid = 1'b0;
    chk("rst err cleared", 32'(err), 32'd0);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_end("restart");
    chk("restart nwrites", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() > 0) begin
      chk("restart addr", wa_q[0], 32'h0);
      chk("restart data", wd_q[0], 32'h44332211);
    end
    $display("restart: writes=%0d done=%0d", wa_q.size(), done_cnt);

    // Reset between bytes 2 and 3 of word 1.
    clear_mon();
    pulse_req();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h06);
    #2 rst = 1'b1;
    #1;
    chk("mid rst we", 32'(mem_we), 32'd0);
    chk("mid rst core_rst", 32'(core_rst), 32'd1);
    chk("mid rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h07); send_byte(8'h08); send_byte(8'h09); send_byte(8'h0A);
    repeat (3) @(negedge clk);
    chk("mid rst nwrites", 32'(wa_q.size()), 32'd1);
    chk("mid rst done", 32'(done_cnt), 32'd0);
    chk("mid rst idle", 32'(busy), 32'd0);
    $display("reset mid-data: writes=%0d", wa_q.size());

    // Randomized loads against the stream model.
    for (int t = 0; t < 20; t++) begin
      int n, r, plen;
      r = $urandom_range(0, 7);
      if (r == 0) n = 0;
      else if (r == 1) n = 1025 + $urandom_range(0, 100);
      else n = $urandom_range(1, 4);
      stream_q.delete();
      stream_q.push_back(n[7:0]);
      stream_q.push_back(n[15:8]);
      plen = (n == 0 || n > 1024) ? 2 : 4 * n;
      if (n > 0 && n <= 1024 && $urandom_range(0, 4) == 0) plen = $urandom_range(0, 4 * n - 1);
      for (int i = 0; i < plen; i++) stream_q.push_back(8'($urandom));
      send_byte(8'($urandom));
      run_load($sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
